fetch_unit: RTL and testbench

- Instruction fetch stage of the RV32I core; sits directly upstream of decode and the immediate generator.
- Holds the PC, issues word fetches to instruction memory over a valid/ready request plus response-valid interface, and presents one instruction at a time to decode over a valid/ready handshake.
- Accepts control-flow redirects (branch/JAL/JALR targets computed from the decoded immediate) and discards stale in-flight fetches.
- Flags misaligned fetch targets instead of issuing them.

---
 rtl/fetch_unit.sv | 131 +++++++++++++
 tb/tb_fetch_unit.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues one word fetch at a time to
// instruction memory, and hands the returned word to decode. Redirects
// replace the PC; any fetch still in flight at a redirect is discarded.
//
// state  | meaning
// S_REQ  | request the word at pc (or flag a fault if pc is misaligned)
// S_WAIT | request accepted, waiting for the response
// S_HOLD | instruction presented to decode, waiting for consumption
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic [31:0] instr_pc_plus4,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic        fetch_fault,
  output logic [31:0] fault_addr
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] instr_pc_q, instr_pc_d;
  logic        instr_valid_q, instr_valid_d;
  logic        drop_q, drop_d;
  logic        in_req;
  logic        pc_aligned;

  assign in_req     = (state_q == S_REQ);
  assign pc_aligned = (pc_q[1:0] == 2'b00);

  assign imem_req_valid = !rst && in_req && pc_aligned;
  assign fetch_fault    = !rst && in_req && !pc_aligned;
  assign imem_addr      = pc_q;
  assign fault_addr     = pc_q;

  assign instr_valid    = instr_valid_q;
  assign instr          = instr_q;
  assign instr_pc       = instr_pc_q;
  assign instr_pc_plus4 = instr_pc_q + 32'd4;

  // State register; reset wins over any transaction in progress.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_REQ;
      pc_q          <= RESET_PC;
      drop_q        <= 1'b0;
      instr_q       <= NOP;
      instr_pc_q    <= 32'h0000_0000;
      instr_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      drop_q        <= drop_d;
      instr_q       <= instr_d;
      instr_pc_q    <= instr_pc_d;
      instr_valid_q <= instr_valid_d;
    end
  end

  // Next-state logic: request, wait for response, hold for decode.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    drop_d        = drop_q;
    instr_d       = instr_q;
    instr_pc_d    = instr_pc_q;
    instr_valid_d = instr_valid_q;

    unique case (state_q)
      S_REQ: begin
        // A redirect coinciding with the handshake lets the old request go
        // out but marks its response as stale.
        if (redirect_valid) pc_d = redirect_target;
        if (pc_aligned && imem_req_ready) begin
          state_d = S_WAIT;
          drop_d  = redirect_valid;
        end
      end
      S_WAIT: begin
        if (imem_rsp_valid) begin
          if (drop_q || redirect_valid) begin
            drop_d  = 1'b0;
            state_d = S_REQ;
            if (redirect_valid) pc_d = redirect_target;
          end else begin
            instr_d       = imem_rsp_data;
            instr_pc_d    = pc_q;
            pc_d          = pc_q + 32'd4;
            instr_valid_d = 1'b1;
            state_d       = S_HOLD;
          end
        end else if (redirect_valid) begin
          pc_d   = redirect_target;
          drop_d = 1'b1;
        end
      end
      S_HOLD: begin
        // Redirect squashes the held instruction even if decode takes it.
        if (redirect_valid) begin
          instr_valid_d = 1'b0;
          pc_d          = redirect_target;
          state_d       = S_REQ;
        end else if (instr_ready) begin
          instr_valid_d = 1'b0;
          state_d       = S_REQ;
        end
      end
      default: state_d = S_REQ;
    endcase
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: a directed stimulus thread with literal checks, a
// memory responder, and a stream-level reference model compared every cycle.
module tb_fetch_unit;

  logic        clk;
  logic        rst;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic [31:0] instr_pc_plus4;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        fetch_fault;
  logic [31:0] fault_addr;

  int checks = 0;
  int errors = 0;

  // memory / model shared state
  int          mem_lat;
  bit          out_q;
  int          rsp_cnt;
  logic [31:0] out_addr;

  fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk             (clk),
    .rst             (rst),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_addr       (imem_addr),
    .imem_rsp_valid  (imem_rsp_valid),
    .imem_rsp_data   (imem_rsp_data),
    .instr_valid     (instr_valid),
    .instr_ready     (instr_ready),
    .instr           (instr),
    .instr_pc        (instr_pc),
    .instr_pc_plus4  (instr_pc_plus4),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .fetch_fault     (fetch_fault),
    .fault_addr      (fault_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0000_0000: return 32'h0050_0093;
      32'h0000_0004: return 32'h00a0_0113;
      default:       return {16'hC0DE, a[15:0]};
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Memory: answers an accepted request rsp_cnt cycles later.
  initial begin
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0;
    forever begin
      @(posedge clk);
      #1;
      imem_rsp_valid = 1'b0;
      if (out_q && rsp_cnt == 1) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = mem_word(out_addr);
      end
    end
  end

  // Reference model: the stream of PCs decode must see, plus protocol rules
  // (one fetch outstanding, fetches stale after any redirect are discarded).
  initial begin
    logic [31:0] next_pc;
    bit          exp_valid;
    bit          stale;
    bit          after_rst;
    bit          req_state;
    bit          exp_req;
    bit          new_valid;
    bit          rsp;
    next_pc   = 32'h0;
    exp_valid = 1'b0;
    stale     = 1'b0;
    after_rst = 1'b0;
    out_q     = 1'b0;
    rsp_cnt   = 0;
    out_addr  = 32'h0;
    forever begin
      @(negedge clk);
      #1;
      if (rst) begin
        chk("m_rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
        chk("m_rst_fault", {31'b0, fetch_fault}, 32'd0);
        next_pc   = 32'h0;
        exp_valid = 1'b0;
        out_q     = 1'b0;
        stale     = 1'b0;
        after_rst = 1'b1;
      end else begin
        req_state = !out_q && !exp_valid;
        exp_req   = req_state && (next_pc[1:0] == 2'b00);
        chk("m_req_valid", {31'b0, imem_req_valid}, {31'b0, exp_req});
        chk("m_fault", {31'b0, fetch_fault}, {31'b0, req_state && (next_pc[1:0] != 2'b00)});
        if (req_state) begin
          chk("m_imem_addr", imem_addr, next_pc);
          chk("m_fault_addr", fault_addr, next_pc);
        end
        chk("m_instr_valid", {31'b0, instr_valid}, {31'b0, exp_valid});
        if (exp_valid) begin
          chk("m_instr", instr, mem_word(next_pc));
          chk("m_instr_pc", instr_pc, next_pc);
          chk("m_instr_pc_plus4", instr_pc_plus4, next_pc + 32'd4);
        end else if (after_rst) begin
          chk("m_rst_instr", instr, 32'h0000_0013);
          chk("m_rst_instr_pc", instr_pc, 32'h0);
          chk("m_rst_plus4", instr_pc_plus4, 32'h4);
        end

        rsp       = imem_rsp_valid && out_q;
        new_valid = exp_valid;
        if (exp_valid && (instr_ready || redirect_valid)) new_valid = 1'b0;
        if (rsp) begin
          if (!(stale || redirect_valid)) new_valid = 1'b1;
          out_q = 1'b0;
        end else if (out_q) begin
          stale   = stale | redirect_valid;
          rsp_cnt = rsp_cnt - 1;
        end
        if (exp_req && imem_req_ready) begin
          out_q    = 1'b1;
          rsp_cnt  = mem_lat;
          out_addr = next_pc;
          stale    = redirect_valid;
        end
        if (redirect_valid) next_pc = redirect_target;
        else if (exp_valid && instr_ready) next_pc = next_pc + 32'd4;
        exp_valid = new_valid;
        if (new_valid) after_rst = 1'b0;
      end
    end
  end

  task automatic cyc(input logic r, input logic rdy, input logic rv,
                     input logic [31:0] tgt, input logic mr);
    @(negedge clk);
    rst             = r;
    instr_ready     = rdy;
    redirect_valid  = rv;
    redirect_target = tgt;
    imem_req_ready  = mr;
    #2;
  endtask

  task automatic wait_instr(input int max_cycles, input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < max_cycles; i++) begin
      cyc(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
      if (instr_valid === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    chk(name, {31'b0, ok}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  // Directed stimulus with hand-computed expectations.
  initial begin
    rst = 1'b1; instr_ready = 1'b1; redirect_valid = 1'b0;
    redirect_target = 32'h0; imem_req_ready = 1'b1; mem_lat = 1;

    // reset and sequential fetch
    cyc(1, 1, 0, 0, 1);
    cyc(1, 1, 0, 0, 1);
    chk("rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
    chk("rst_instr_valid", {31'b0, instr_valid}, 32'd0);
    chk("rst_instr", instr, 32'h0000_0013);
    cyc(0, 1, 0, 0, 1);
    chk("c0_req_valid", {31'b0, imem_req_valid}, 32'd1);
    chk("c0_addr", imem_addr, 32'h0);
    cyc(0, 1, 0, 0, 1);
    cyc(0, 1, 0, 0, 1);
    chk("seq0_valid", {31'b0, instr_valid}, 32'd1);
    chk("seq0_instr", instr, 32'h0050_0093);
    chk("seq0_pc", instr_pc, 32'h0);
    chk("seq0_plus4", instr_pc_plus4, 32'h4);
    cyc(0, 1, 0, 0, 1);
    chk("seq1_addr", imem_addr, 32'h4);
    chk("seq1_req", {31'b0, imem_req_valid}, 32'd1);
    cyc(0, 1, 0, 0, 1);
    cyc(0, 1, 0, 0, 1);
    chk("seq1_valid", {31'b0, instr_valid}, 32'd1);
    chk("seq1_instr", instr, 32'h00a0_0113);
    chk("seq1_pc", instr_pc, 32'h4);
    cyc(0, 1, 0, 0, 1);
    chk("seq2_addr", imem_addr, 32'h8);
    // redirect in S_WAIT, the response for 8 must vanish
    cyc(0, 1, 1, 32'h100, 1);
    chk("rw_valid", {31'b0, instr_valid}, 32'd0);
    cyc(0, 1, 0, 0, 1);
    chk("rw_req", {31'b0, imem_req_valid}, 32'd1);
    chk("rw_addr", imem_addr, 32'h100);
    cyc(0, 1, 0, 0, 1);
    cyc(0, 1, 0, 0, 1);
    chk("rw_instr_valid", {31'b0, instr_valid}, 32'd1);
    chk("rw_instr_pc", instr_pc, 32'h100);
    chk("rw_instr", instr, 32'hC0DE_0100);

    // backpressure
    cyc(1, 0, 0, 0, 1);
    cyc(1, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 1);
    chk("bp_addr0", imem_addr, 32'h0);
    cyc(0, 0, 0, 0, 1);
    for (int i = 0; i < 5; i++) begin
      cyc(0, 0, 0, 0, 1);
      chk("bp_valid", {31'b0, instr_valid}, 32'd1);
      chk("bp_instr", instr, 32'h0050_0093);
      chk("bp_pc", instr_pc, 32'h0);
      chk("bp_req", {31'b0, imem_req_valid}, 32'd0);
    end
    cyc(0, 1, 0, 0, 1);
    cyc(0, 1, 0, 0, 1);
    chk("bp_next_req", {31'b0, imem_req_valid}, 32'd1);
    chk("bp_next_addr", imem_addr, 32'h4);
    cyc(0, 1, 0, 0, 1);
    // redirect in S_HOLD with ready high
    cyc(0, 1, 1, 32'h40, 1);
    chk("rh_valid", {31'b0, instr_valid}, 32'd1);
    chk("rh_pc", instr_pc, 32'h4);
    cyc(0, 1, 0, 0, 0);
    chk("rh_squash", {31'b0, instr_valid}, 32'd0);
    chk("rh_req", {31'b0, imem_req_valid}, 32'd1);
    chk("rh_addr", imem_addr, 32'h40);

    // misaligned target
    cyc(0, 1, 1, 32'h102, 0);
    cyc(0, 1, 0, 0, 1);
    chk("mis_fault", {31'b0, fetch_fault}, 32'd1);
    chk("mis_fault_addr", fault_addr, 32'h102);
    chk("mis_req", {31'b0, imem_req_valid}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      cyc(0, 1, 0, 0, 1);
      chk("mis_fault_hold", {31'b0, fetch_fault}, 32'd1);
      chk("mis_req_hold", {31'b0, imem_req_valid}, 32'd0);
    end
    cyc(0, 1, 1, 32'h200, 1);
    mem_lat = 3;
    cyc(0, 1, 0, 0, 1);
    chk("mis_clear", {31'b0, fetch_fault}, 32'd0);
    chk("mis_req_200", {31'b0, imem_req_valid}, 32'd1);
    chk("mis_addr_200", imem_addr, 32'h200);

    // redirect in S_WAIT before a slow response arrives
    cyc(0, 1, 1, 32'h300, 1);
    cyc(0, 1, 0, 0, 1);
    chk("drop_valid_a", {31'b0, instr_valid}, 32'd0);
    cyc(0, 1, 0, 0, 1);
    chk("drop_req_a", {31'b0, imem_req_valid}, 32'd0);
    cyc(0, 1, 0, 0, 1);
    chk("drop_valid_b", {31'b0, instr_valid}, 32'd0);
    chk("drop_req_300", {31'b0, imem_req_valid}, 32'd1);
    chk("drop_addr_300", imem_addr, 32'h300);
    mem_lat = 1;
    wait_instr(10, "drop_wait_timeout");
    chk("drop_instr_pc", instr_pc, 32'h300);
    chk("drop_instr", instr, 32'hC0DE_0300);

    // redirect on the handshake cycle, then PC wrap
    cyc(0, 1, 1, 32'hFFFF_FFFC, 1);
    chk("hs_addr", imem_addr, 32'h304);
    cyc(0, 1, 0, 0, 1);
    cyc(0, 1, 0, 0, 1);
    chk("wrap_req", {31'b0, imem_req_valid}, 32'd1);
    chk("wrap_addr", imem_addr, 32'hFFFF_FFFC);
    wait_instr(10, "wrap_wait_timeout");
    chk("wrap_instr_pc", instr_pc, 32'hFFFF_FFFC);
    chk("wrap_plus4", instr_pc_plus4, 32'h0);
    chk("wrap_instr", instr, 32'hC0DE_FFFC);
    cyc(0, 1, 0, 0, 1);
    chk("wrap_next_req", {31'b0, imem_req_valid}, 32'd1);
    chk("wrap_next_addr", imem_addr, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
